// File: rtl/sdiv_seq.sv
// Signed restoring divider: one quotient bit per clock, go/rdy handshake.
// Unsigned magnitude core with a single conditional negate per output on completion.
module sdiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dsr_mag;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg, dbz_pend, ovf_pend;

  logic [WIDTH-1:0] dvd_mag_in, dsr_mag_in;
  logic [WIDTH+1:0] shifted, trial;
  logic [WIDTH-1:0] rem_src, q_fix, r_fix;

  always_comb begin
    dvd_mag_in = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_mag_in = divisor[WIDTH-1]  ? -divisor  : divisor;
    shifted    = {prem, dvd_sh[WIDTH-1]};
    trial      = shifted - {2'b00, dsr_mag};
    // On divide-by-zero the iteration is skipped, so dvd_sh still holds |dividend|.
    rem_src    = dbz_pend ? dvd_sh : prem[WIDTH-1:0];
    q_fix      = dbz_pend ? '1 : (q_neg ? -dvd_sh : dvd_sh);
    r_fix      = r_neg ? -rem_src : rem_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = (divisor == '0) ? FIX : DIV;
      DIV:  if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem        <= '0;
      dvd_sh      <= '0;
      dsr_mag     <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_pend    <= 1'b0;
      ovf_pend    <= 1'b0;
      busy        <= 1'b0;
      rdy         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          dvd_sh      <= dvd_mag_in;
          dsr_mag     <= dsr_mag_in;
          prem        <= '0;
          q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg       <= dividend[WIDTH-1];
          dbz_pend    <= (divisor == '0);
          ovf_pend    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
          cnt         <= CNT_W'(WIDTH);
          rdy         <= 1'b0;
          ovf         <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b1;
        end
        DIV: begin
          prem   <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          dvd_sh <= {dvd_sh[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          ovf         <= ovf_pend;
          div_by_zero <= dbz_pend;
          rdy         <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
